// File: rtl/cpu_pkg.sv
// Shared types for the NZCV flag stage: condition codes, skid-buffer
// states and the bit positions of each flag inside a 4-bit NZCV vector.
package cpu_pkg;

  // Bit positions within an NZCV vector
  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  // Condition codes, encoded as presented on i_cond
  typedef enum logic [3:0] {
    EQ = 4'd0,
    NE = 4'd1,
    CS = 4'd2,
    CC = 4'd3,
    MI = 4'd4,
    PL = 4'd5,
    VS = 4'd6,
    VC = 4'd7,
    HI = 4'd8,
    LS = 4'd9,
    GE = 4'd10,
    LT = 4'd11,
    GT = 4'd12,
    LE = 4'd13,
    AL = 4'd14,
    NV = 4'd15
  } cond_e;

  // Skid buffer occupancy: EMPTY = nothing held, BUSY = main only,
  // FULL = main and skid both hold entries
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: decides whether a condition
// holds for a given NZCV flag vector. Codes 14 and 15 always hold.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] i_flags,
  input  logic [3:0] i_cond,
  output logic       o_taken
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_ge;
  logic w_hi;
  logic w_gt;

  assign w_n  = i_flags[NZCV_N];
  assign w_z  = i_flags[NZCV_Z];
  assign w_c  = i_flags[NZCV_C];
  assign w_v  = i_flags[NZCV_V];
  assign w_ge = (w_n == w_v);
  assign w_hi = w_c & ~w_z;
  assign w_gt = ~w_z & w_ge;

  // Decode the condition code against the flags
  always_comb begin
    o_taken = 1'b1;
    case (cond_e'(i_cond))
      EQ:      o_taken = w_z;
      NE:      o_taken = ~w_z;
      CS:      o_taken = w_c;
      CC:      o_taken = ~w_c;
      MI:      o_taken = w_n;
      PL:      o_taken = ~w_n;
      VS:      o_taken = w_v;
      VC:      o_taken = ~w_v;
      HI:      o_taken = w_hi;
      LS:      o_taken = ~w_hi;
      GE:      o_taken = w_ge;
      LT:      o_taken = ~w_ge;
      GT:      o_taken = w_gt;
      LE:      o_taken = ~w_gt;
      default: o_taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/nzcv_flag_stage.sv
// NZCV flag stage: a 2-entry skid buffer carrying ALU results, with the
// condition outcome of each operation evaluated against the architectural
// flag register at the moment the operation is accepted.
// Optional feature: define NZCV_FLAG_STAGE_STATS_EN to add o_taken_cnt,
// a saturating count of emitted entries whose condition was taken.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and its payload until that edge;
// o_ready depends only on registered state, never on i_ready, and o_result /
// o_taken stay stable while o_valid is high and i_ready is low.
module nzcv_flag_stage
  import cpu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_result,
  input  logic [3:0]   i_nzcv,
  input  logic         i_set_flags,
  input  logic [3:0]   i_cond,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result,
  output logic         o_taken,
  output logic [3:0]   o_flags,
  output state_e       o_dbg_state
`ifdef NZCV_FLAG_STAGE_STATS_EN
  ,
  output logic [31:0]  o_taken_cnt
`endif
);

  state_e       r_state;
  state_e       w_state_nxt;
  logic [N-1:0] r_main_result;
  logic         r_main_taken;
  logic [N-1:0] r_skid_result;
  logic         r_skid_taken;
  logic [3:0]   r_flags;

  logic         w_accept;
  logic         w_emit;
  logic         w_taken;
  logic         w_load_main_new;
  logic         w_load_main_skid;
  logic         w_load_skid;

  assign o_ready     = (r_state != ST_FULL);
  assign o_valid     = (r_state != ST_EMPTY);
  assign o_result    = r_main_result;
  assign o_taken     = r_main_taken;
  assign o_flags     = r_flags;
  assign o_dbg_state = r_state;

  assign w_accept = i_valid & o_ready;
  assign w_emit   = o_valid & i_ready;

  // Condition is judged against the flags as they stand before this
  // operation's own flag update
  cond_eval u_cond_eval (
    .i_flags (r_flags),
    .i_cond  (i_cond),
    .o_taken (w_taken)
  );

  // Next-state and buffer load decisions
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_new  = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt     = ST_BUSY;
          w_load_main_new = 1'b1;
        end
      end
      ST_BUSY: begin
        if (w_accept && !w_emit) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_emit && !w_accept) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_emit && w_accept) begin
          w_state_nxt     = ST_BUSY;
          w_load_main_new = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_emit) begin
          w_state_nxt      = ST_BUSY;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Main and skid entry storage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_main_result <= '0;
      r_main_taken  <= 1'b0;
      r_skid_result <= '0;
      r_skid_taken  <= 1'b0;
    end else begin
      if (w_load_main_new) begin
        r_main_result <= i_result;
        r_main_taken  <= w_taken;
      end else if (w_load_main_skid) begin
        r_main_result <= r_skid_result;
        r_main_taken  <= r_skid_taken;
      end
      if (w_load_skid) begin
        r_skid_result <= i_result;
        r_skid_taken  <= w_taken;
      end
    end
  end

  // Architectural flag register, written by accepted flag-setting ops
  always_ff @(posedge i_clk) begin
    if (i_rst)                       r_flags <= 4'b0000;
    else if (w_accept && i_set_flags) r_flags <= i_nzcv;
  end

`ifdef NZCV_FLAG_STAGE_STATS_EN
  logic [31:0] r_taken_cnt;
  assign o_taken_cnt = r_taken_cnt;

  // Saturating count of emitted entries whose condition held
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_taken_cnt <= 32'd0;
    end else if (w_emit && r_main_taken && (r_taken_cnt != 32'hFFFF_FFFF)) begin
      r_taken_cnt <= r_taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nzcv_flag_stage.sv
// Testbench for nzcv_flag_stage. Expected {result, taken} pairs are pushed
// when an accept is seen and popped when the stage emits; flags are tracked
// by a small reference model.
module tb_nzcv_flag_stage;
  import cpu_pkg::*;

  localparam int N = 64;

  logic         clk;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_result;
  logic [3:0]   i_nzcv;
  logic         i_set_flags;
  logic [3:0]   i_cond;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_result;
  logic         o_taken;
  logic [3:0]   o_flags;
  state_e       dbg_state;
`ifdef NZCV_FLAG_STAGE_STATS_EN
  logic [31:0]  o_taken_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [N:0] exp_q[$];
  logic [3:0] m_flags;

  nzcv_flag_stage #(.N(N)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_result    (i_result),
    .i_nzcv      (i_nzcv),
    .i_set_flags (i_set_flags),
    .i_cond      (i_cond),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_taken     (o_taken),
    .o_flags     (o_flags),
    .o_dbg_state (dbg_state)
`ifdef NZCV_FLAG_STAGE_STATS_EN
    ,
    .o_taken_cnt (o_taken_cnt)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference condition decode
  function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  // One clock: scoreboard at the falling edge, then advance past the
  // rising edge so tasks may drive the next cycle's inputs
  task automatic tick();
    logic [N:0] exp;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      m_flags = 4'b0000;
    end else begin
      if (o_valid && i_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_emit got result=%0h taken=%0b required no emit", o_result, o_taken);
        end else begin
          exp = exp_q.pop_front();
          if ({o_result, o_taken} !== exp) begin
            n_fail++;
            $display("FAIL sb_emit got result=%0h taken=%0b required result=%0h taken=%0b",
                     o_result, o_taken, exp[N:1], exp[0]);
          end
        end
      end
      if (i_valid && o_ready) begin
        exp_q.push_back({i_result, ref_cond(m_flags, i_cond)});
        if (i_set_flags) m_flags = i_nzcv;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] r, input logic [3:0] nz,
                       input logic sf, input logic [3:0] c);
    i_valid     = v;
    i_result    = r;
    i_nzcv      = nz;
    i_set_flags = sf;
    i_cond      = c;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 64'hDEAD, 4'b1111, 1'b1, 4'd14);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, '0, 4'b0000, 1'b0, 4'd0);
  endtask

  task automatic test_reset();
    i_ready = 1'b1;
    do_reset();
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_handshake got valid=%0b ready=%0b required valid=0 ready=1", o_valid, o_ready);
    end
    n_checks++;
    if (o_flags !== 4'b0000 || o_result !== '0 || o_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values got flags=%b result=%0h taken=%0b required 0000/0/0", o_flags, o_result, o_taken);
    end
  endtask

  task automatic test_basic();
    i_ready = 1'b1;
    drive(1'b1, 64'd5, 4'b0100, 1'b1, 4'd0);
    tick();
    n_checks++;
    if (o_valid !== 1'b1 || o_result !== 64'd5 || o_taken !== 1'b0 || o_flags !== 4'b0100) begin
      n_fail++;
      $display("FAIL basic_first got valid=%0b result=%0h taken=%0b flags=%b required 1/5/0/0100",
               o_valid, o_result, o_taken, o_flags);
    end
    drive(1'b1, 64'd6, 4'b0000, 1'b0, 4'd0);
    tick();
    n_checks++;
    if (o_valid !== 1'b1 || o_result !== 64'd6 || o_taken !== 1'b1 || o_flags !== 4'b0100) begin
      n_fail++;
      $display("FAIL basic_followup got valid=%0b result=%0h taken=%0b flags=%b required 1/6/1/0100",
               o_valid, o_result, o_taken, o_flags);
    end
    drive(1'b0, '0, 4'b0000, 1'b0, 4'd0);
    tick();
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain got valid=%0b required 0", o_valid);
    end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b0;
    drive(1'b1, 64'h10, 4'b0000, 1'b0, 4'd14);
    tick();
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_one got ready=%0b required 1", o_ready);
    end
    drive(1'b1, 64'h11, 4'b0000, 1'b0, 4'd14);
    tick();
    n_checks++;
    if (o_ready !== 1'b0 || o_result !== 64'h10) begin
      n_fail++;
      $display("FAIL b2b_full got ready=%0b result=%0h required 0/10", o_ready, o_result);
    end
    drive(1'b1, 64'h12, 4'b0000, 1'b0, 4'd14);
    tick();
    n_checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_result !== 64'h10) begin
      n_fail++;
      $display("FAIL b2b_hold got ready=%0b valid=%0b result=%0h required 0/1/10", o_ready, o_valid, o_result);
    end
    i_ready = 1'b1;
    tick();
    tick();
    drive(1'b0, '0, 4'b0000, 1'b0, 4'd0);
    tick();
    tick();
    n_checks++;
    if (o_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drained got valid=%0b pending=%0d required 0/0", o_valid, exp_q.size());
    end
  endtask

  task automatic test_cond();
    i_ready = 1'b1;
    drive(1'b1, 64'h20, 4'b1001, 1'b1, 4'd14);
    tick();
    drive(1'b1, 64'h21, 4'b0000, 1'b0, 4'd10);
    tick();
    n_checks++;
    if (o_taken !== 1'b1 || o_flags !== 4'b1001) begin
      n_fail++;
      $display("FAIL cond_ge got taken=%0b flags=%b required 1/1001", o_taken, o_flags);
    end
    drive(1'b1, 64'h22, 4'b1101, 1'b1, 4'd14);
    tick();
    drive(1'b1, 64'h23, 4'b0000, 1'b0, 4'd12);
    tick();
    n_checks++;
    if (o_taken !== 1'b0 || o_flags !== 4'b1101) begin
      n_fail++;
      $display("FAIL cond_gt got taken=%0b flags=%b required 0/1101", o_taken, o_flags);
    end
    drive(1'b0, '0, 4'b0000, 1'b0, 4'd0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom(), $urandom()}, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      i_ready = ($urandom_range(0, 3) != 0);
      tick();
      n_checks++;
      if (o_flags !== m_flags) begin
        n_fail++;
        $display("FAIL rand_flags got flags=%b required %b", o_flags, m_flags);
      end
    end
    drive(1'b0, '0, 4'b0000, 1'b0, 4'd0);
    i_ready = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if (exp_q.size() != 0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_drain got pending=%0d valid=%0b required 0/0", exp_q.size(), o_valid);
    end
  endtask

  task automatic test_reset_full();
    i_ready = 1'b0;
    drive(1'b1, 64'h30, 4'b1111, 1'b1, 4'd14);
    tick();
    drive(1'b1, 64'h31, 4'b1010, 1'b1, 4'd14);
    tick();
    n_checks++;
    if (o_ready !== 1'b0 || o_flags !== 4'b1010) begin
      n_fail++;
      $display("FAIL rstfull_setup got ready=%0b flags=%b required 0/1010", o_ready, o_flags);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_ready = 1'b1;
    drive(1'b0, '0, 4'b0000, 1'b0, 4'd0);
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstfull_after got valid=%0b ready=%0b flags=%b required 0/1/0000", o_valid, o_ready, o_flags);
    end
    tick();
    tick();
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstfull_stale got valid=%0b required 0", o_valid);
    end
  endtask

`ifdef NZCV_FLAG_STAGE_STATS_EN
  task automatic test_stats();
    do_reset();
    n_checks++;
    if (o_taken_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_reset got cnt=%0d required 0", o_taken_cnt);
    end
    i_ready = 1'b1;
    drive(1'b1, 64'h40, 4'b0000, 1'b0, 4'd14); tick();
    drive(1'b1, 64'h41, 4'b0000, 1'b0, 4'd0);  tick();
    drive(1'b1, 64'h42, 4'b0000, 1'b0, 4'd14); tick();
    drive(1'b1, 64'h43, 4'b0000, 1'b0, 4'd0);  tick();
    drive(1'b1, 64'h44, 4'b0000, 1'b0, 4'd14); tick();
    drive(1'b0, '0, 4'b0000, 1'b0, 4'd0);
    tick();
    tick();
    n_checks++;
    if (o_taken_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL stats_count got cnt=%0d required 3", o_taken_cnt);
    end
  endtask
`endif

  initial begin
    rst     = 1'b1;
    i_ready = 1'b0;
    m_flags = 4'b0000;
    drive(1'b0, '0, 4'b0000, 1'b0, 4'd0);
    test_reset();
    test_basic();
    test_back_to_back();
    test_cond();
    test_random();
    test_reset_full();
`ifdef NZCV_FLAG_STAGE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
